// File: rtl/mul_pkg.sv
// Shared types and width helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned W_DEF  = 8;
    localparam int unsigned PW_DEF = 2 * W_DEF;

    // Width of the bit-index counter; it must hold W-1.
    function automatic int unsigned cnt_w(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mul_abs.sv
// Operand magnitude: two's complement absolute value when sgn=1, raw value otherwise.
module mul_abs #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x,
    input  logic         sgn,
    output logic [W-1:0] mag_c
);

    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign mag_c = (sgn && x[W-1]) ? W'(-x) : x;

endmodule

// File: rtl/mul_seq.sv
// Parametrised sequential shift-add multiplier, MSB-first, W cycles per product.
module mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              start,
    input  logic              sgn,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              busy,
    output logic              fin,
    output logic [2*W-1:0]    o
);

    localparam int unsigned PW = prod_w(W);
    localparam int unsigned CW = cnt_w(W);

    state_t          state_q, state_d;
    logic [W-1:0]    am_q, am_d;
    logic [W-1:0]    bm_q, bm_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   y_q, y_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_d;
    logic            fin_d;
    logic [PW-1:0]   o_d;

    logic [W-1:0]    am_c;
    logic [W-1:0]    bm_c;
    logic [PW-1:0]   sum_c;

    mul_abs #(.W(W)) u_abs_a (
        .x     (a),
        .sgn   (sgn),
        .mag_c (am_c)
    );

    mul_abs #(.W(W)) u_abs_b (
        .x     (b),
        .sgn   (sgn),
        .mag_c (bm_c)
    );

    // One shift-add step on the current multiplier bit.
    assign sum_c = (y_q << 1) + (bm_q[cnt_q] ? PW'(am_q) : PW'(0));

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        am_d    = am_q;
        bm_d    = bm_q;
        neg_d   = neg_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        fin_d   = 1'b0;
        o_d     = o;

        case (state_q)
            IDLE: begin
                if (start) begin
                    am_d    = am_c;
                    bm_d    = bm_c;
                    neg_d   = sgn & (a[W-1] ^ b[W-1]);
                    y_d     = '0;
                    cnt_d   = CW'(W - 1);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    // Negating a zero sum yields zero, so no -0 can appear.
                    o_d     = neg_q ? PW'(-sum_c) : sum_c;
                    fin_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    y_d   = sum_c;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            am_q    <= '0;
            bm_q    <= '0;
            neg_q   <= 1'b0;
            y_q     <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            fin     <= 1'b0;
            o       <= '0;
        end else begin
            state_q <= state_d;
            am_q    <= am_d;
            bm_q    <= bm_d;
            neg_q   <= neg_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            fin     <= fin_d;
            o       <= o_d;
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq at W=2, 8 and 16 against an arithmetic reference product.
module tb_mul_seq;

    logic        ck;
    logic        rst;
    logic        start;
    logic        s;
    logic [31:0] av;
    logic [31:0] bv;
    int          sel;

    logic        st2, st8, st16;
    logic        busy2, fin2;
    logic        busy8, fin8;
    logic        busy16, fin16;
    logic [3:0]  o2;
    logic [15:0] o8;
    logic [31:0] o16;

    logic        ob;
    logic        of;
    logic [63:0] oo;

    int n_chk;
    int n_pass;

    assign st2  = start && (sel == 2);
    assign st8  = start && (sel == 8);
    assign st16 = start && (sel == 16);

    mul_seq #(.W(2)) u_dut2 (
        .ck(ck), .rst(rst), .start(st2), .sgn(s), .a(av[1:0]), .b(bv[1:0]),
        .busy(busy2), .fin(fin2), .o(o2)
    );

    mul_seq #(.W(8)) u_dut8 (
        .ck(ck), .rst(rst), .start(st8), .sgn(s), .a(av[7:0]), .b(bv[7:0]),
        .busy(busy8), .fin(fin8), .o(o8)
    );

    mul_seq #(.W(16)) u_dut16 (
        .ck(ck), .rst(rst), .start(st16), .sgn(s), .a(av[15:0]), .b(bv[15:0]),
        .busy(busy16), .fin(fin16), .o(o16)
    );

    always_comb begin
        ob = busy8;
        of = fin8;
        oo = 64'(o8);
        case (sel)
            2:  begin ob = busy2;  of = fin2;  oo = 64'(o2);  end
            16: begin ob = busy16; of = fin16; oo = 64'(o16); end
            default: ;
        endcase
    end

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Mathematical product of two w-bit operands, truncated to 2w bits.
    function automatic logic [63:0] ref_prod(input int w, input bit sg,
                                             input logic [31:0] x, input logic [31:0] y);
        longint      xi, yi, p;
        logic [63:0] mask;
        xi = longint'(64'(x) & ((64'd1 << w) - 64'd1));
        yi = longint'(64'(y) & ((64'd1 << w) - 64'd1));
        if (sg && x[w-1]) xi = xi - (longint'(1) << w);
        if (sg && y[w-1]) yi = yi - (longint'(1) << w);
        p    = xi * yi;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    // Called at a negedge; returns at the negedge following the capture edge.
    task automatic launch(input int w, input bit sg, input logic [31:0] x, input logic [31:0] y);
        sel   = w;
        s     = sg;
        av    = x;
        bv    = y;
        start = 1'b1;
        @(posedge ck);
        @(negedge ck);
        start = 1'b0;
        s     = 1'($urandom);
        av    = $urandom;
        bv    = $urandom;
    endtask

    // Counts edges until fin is seen, and the samples with busy high.
    task automatic wait_fin(output int cyc, output int nb);
        cyc = 0;
        nb  = ob ? 1 : 0;
        while (!of && cyc < 200) begin
            @(negedge ck);
            cyc++;
            if (ob) nb++;
        end
    endtask

    task automatic run_check(input int w, input bit sg, input logic [31:0] x,
                             input logic [31:0] y, input logic [63:0] exp, input string tag);
        int cyc, nb;
        launch(w, sg, x, y);
        wait_fin(cyc, nb);
        chk({tag, "_o"}, oo, exp);
        chk({tag, "_lat"}, 64'(cyc), 64'(w));
        chk({tag, "_busy"}, 64'(nb), 64'(w));
    endtask

    initial begin
        int cyc, nb, nfin;
        logic [31:0] x, y;
        bit sg;

        n_chk = 0;
        n_pass = 0;
        rst   = 1'b1;
        start = 1'b0;
        s     = 1'b0;
        av    = '0;
        bv    = '0;
        sel   = 8;
        repeat (2) @(negedge ck);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_fin8", 64'(fin8), 64'd0);
        chk("rst_o8", 64'(o8), 64'd0);
        chk("rst_busy16", 64'(busy16), 64'd0);
        chk("rst_o2", 64'(o2), 64'd0);
        rst = 1'b0;
        @(negedge ck);

        // Directed cases at W=8.
        run_check(8, 1'b0, 32'd255, 32'd255, 64'hFE01, "u255x255");
        @(negedge ck);
        chk("fin_pulse", 64'(fin8), 64'd0);
        chk("o_hold", 64'(o8), 64'hFE01);
        run_check(8, 1'b1, 32'h80, 32'h80, 64'h4000, "s80x80");
        run_check(8, 1'b1, 32'hFD, 32'h05, 64'hFFF1, "sm3x5");
        run_check(8, 1'b1, 32'h00, 32'h80, 64'h0000, "s0x80");
        run_check(8, 1'b1, 32'h01, 32'h00, 64'h0000, "neg_zero");

        // Start while busy is ignored; start on the fin cycle is accepted.
        launch(8, 1'b0, 32'd3, 32'd4);
        repeat (2) @(negedge ck);
        start = 1'b1;
        av    = 32'd9;
        bv    = 32'd9;
        @(negedge ck);
        start = 1'b0;
        wait_fin(cyc, nb);
        chk("ign_lat", 64'(cyc), 64'd5);
        chk("ign_o", 64'(o8), 64'd12);
        launch(8, 1'b0, 32'd9, 32'd9);
        wait_fin(cyc, nb);
        chk("b2b_fin2fin", 64'(cyc + 1), 64'd9);
        chk("b2b_o", 64'(o8), 64'd81);

        // Asynchronous reset between edges mid-operation.
        launch(8, 1'b0, 32'd200, 32'd100);
        repeat (3) @(negedge ck);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy8), 64'd0);
        chk("arst_fin", 64'(fin8), 64'd0);
        chk("arst_o", 64'(o8), 64'd0);
        @(negedge ck);
        rst = 1'b0;
        nfin = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge ck);
            if (fin8) nfin++;
        end
        chk("arst_nofin", 64'(nfin), 64'd0);
        run_check(8, 1'b1, 32'hFF, 32'h7F, 64'hFF81, "post_rst");

        // W=2 exhaustive in both modes.
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    run_check(2, 1'(m), 32'(i), 32'(j), ref_prod(2, 1'(m), 32'(i), 32'(j)),
                              $sformatf("w2_m%0d_%0dx%0d", m, i, j));

        // W=8 and W=16 random in both modes.
        for (int i = 0; i < 200; i++) begin
            x  = $urandom;
            y  = $urandom;
            sg = 1'($urandom);
            run_check(8, sg, x, y, ref_prod(8, sg, x, y), $sformatf("w8_r%0d", i));
        end
        for (int i = 0; i < 1000; i++) begin
            x  = $urandom;
            y  = $urandom;
            sg = 1'(i & 1);
            run_check(16, sg, x, y, ref_prod(16, sg, x, y), $sformatf("w16_r%0d", i));
        end
        run_check(16, 1'b1, 32'h8000, 32'h8000, 64'h4000_0000, "w16_minmin");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
